// File: rtl/divisor_seq.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Produces a WIDTH-bit quotient (div_lo) and remainder (div_hi) in either
// unsigned or two's-complement mode, selected per operation. A zero divisor
// finishes one cycle after start, with the flag set and a fixed result.
module divisor_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic             divby0flag
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic             mode_q,     mode_d;      // 1 = signed operation
    logic [WIDTH-1:0] dvd_q,      dvd_d;       // dividend (magnitude after PREP)
    logic [WIDTH-1:0] dvs_q,      dvs_d;       // divisor (magnitude after PREP)
    logic [WIDTH-1:0] rem_q,      rem_d;       // partial remainder
    logic [WIDTH-1:0] quo_q,      quo_d;       // quotient bits shifted in MSB first
    logic [CW-1:0]    cnt_q,      cnt_d;       // dividend bit being brought down
    logic             neg_quo_q,  neg_quo_d;   // quotient must be negated in FIX
    logic             neg_rem_q,  neg_rem_d;   // remainder must be negated in FIX
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [WIDTH-1:0] div_lo_q,   div_lo_d;
    logic [WIDTH-1:0] div_hi_q,   div_hi_d;
    logic             flag_q,     flag_d;

    // Trial remainder is one bit wider so the compare/subtract never wraps.
    logic [WIDTH:0]   trial;
    logic             q_bit;

    // Next-state and next-output computation for the whole divider.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;              // done is a single-cycle pulse
        div_lo_d  = div_lo_q;
        div_hi_d  = div_hi_q;
        flag_d    = flag_q;
        trial     = {rem_q, dvd_q[cnt_q]};
        q_bit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    mode_d  = signed_op;
                    busy_d  = 1'b1;
                    flag_d  = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (dvs_q == '0) begin
                    // Divide by zero: all-ones quotient, raw dividend as remainder.
                    div_lo_d = '1;
                    div_hi_d = dvd_q;
                    flag_d   = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    // Work on magnitudes; the signs are reapplied in FIX.
                    dvd_d     = (mode_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                    dvs_d     = (mode_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    neg_quo_d = mode_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    neg_rem_d = mode_q & dvd_q[WIDTH-1];
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = ITER;
                end
            end
            ITER: begin
                if (trial >= {1'b0, dvs_q}) begin
                    trial = trial - {1'b0, dvs_q};
                    q_bit = 1'b1;
                end
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                div_lo_d = neg_quo_q ? -quo_q : quo_q;
                div_hi_d = neg_rem_q ? -rem_q : rem_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div_lo_q  <= '0;
            div_hi_q  <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div_lo_q  <= div_lo_d;
            div_hi_q  <= div_hi_d;
            flag_q    <= flag_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign div_lo     = div_lo_q;
    assign div_hi     = div_hi_q;
    assign divby0flag = flag_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Bench for divisor_seq: three builds (WIDTH 8, 16, 32) run side by side.
// An arithmetic reference model predicts busy/done/results every cycle;
// directed operations with literal expectations pin both DUT and model.
module tb_divisor_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [2:0]       start_s, sop_s;
    logic [2:0][31:0] dvd_s, dvs_s;
    logic [2:0]       busy_s, done_s, flag_s;
    logic [2:0][31:0] lo_s, hi_s;

    int checks   = 0;
    int failures = 0;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 16 : 32);
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 16 : 32);
        logic [W-1:0] lo_w, hi_w;
        logic         busy_w, done_w, flag_w;
        divisor_seq #(.WIDTH(W)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start_s[gi]),
            .signed_op  (sop_s[gi]),
            .dividend   (dvd_s[gi][W-1:0]),
            .divisor    (dvs_s[gi][W-1:0]),
            .busy       (busy_w),
            .done       (done_w),
            .div_lo     (lo_w),
            .div_hi     (hi_w),
            .divby0flag (flag_w)
        );
        assign busy_s[gi] = busy_w;
        assign done_s[gi] = done_w;
        assign flag_s[gi] = flag_w;
        assign lo_s[gi]   = 32'(lo_w);
        assign hi_s[gi]   = 32'(hi_w);
    end

    // Reference division by plain integer arithmetic on w-bit operands.
    function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input bit sgn, output logic [31:0] lo,
                                    output logic [31:0] hi, output bit flag);
        longint sa, sb, q, r, m;
        m = (longint'(1) << w) - 1;
        if (b == 32'd0) begin
            lo   = mask_of(w);
            hi   = a;
            flag = 1'b1;
            return;
        end
        flag = 1'b0;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        q  = sa / sb;
        r  = sa % sb;
        q  = q & m;
        r  = r & m;
        lo = q[31:0];
        hi = r[31:0];
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s w%0d: got 0x%0h expected 0x%0h", name, wid(i), act, exp);
        end
    endtask

    // Behavioural model state
    bit          m_busy [3];
    bit          m_done [3];
    bit          m_flag [3];
    bit          m_rflag[3];
    int          m_cnt  [3];
    logic [31:0] m_lo [3], m_hi [3], m_rlo [3], m_rhi [3];

    // Model: accept start only when idle; result appears after a fixed latency.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_flag[i] = 0; m_cnt[i] = 0;
                m_lo[i] = 0; m_hi[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                        m_lo[i]   = m_rlo[i];
                        m_hi[i]   = m_rhi[i];
                        m_flag[i] = m_rflag[i];
                    end
                end else if (start_s[i]) begin
                    m_busy[i] = 1;
                    m_flag[i] = 0;
                    ref_div(wid(i), dvd_s[i] & mask_of(wid(i)), dvs_s[i] & mask_of(wid(i)),
                            sop_s[i], m_rlo[i], m_rhi[i], m_rflag[i]);
                    m_cnt[i] = m_rflag[i] ? 1 : wid(i) + 2;
                end
            end
        end
    end

    // Compare every DUT output against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy",   i, 32'(busy_s[i]), 32'(m_busy[i]));
                chk("done",   i, 32'(done_s[i]), 32'(m_done[i]));
                chk("div_lo", i, lo_s[i], m_lo[i]);
                chk("div_hi", i, hi_s[i], m_hi[i]);
                chk("flag",   i, 32'(flag_s[i]), 32'(m_flag[i]));
            end
        end
    end

    task automatic chk_zero_all(input string name);
        for (int i = 0; i < 3; i++) begin
            chk({name, "_busy"}, i, 32'(busy_s[i]), 32'd0);
            chk({name, "_done"}, i, 32'(done_s[i]), 32'd0);
            chk({name, "_lo"},   i, lo_s[i], 32'd0);
            chk({name, "_hi"},   i, hi_s[i], 32'd0);
            chk({name, "_flag"}, i, 32'(flag_s[i]), 32'd0);
        end
    endtask

    task automatic chk_model(input int w, input logic [31:0] a, input logic [31:0] b,
                             input bit s, input logic [31:0] elo, input logic [31:0] ehi,
                             input bit ef);
        logic [31:0] lo, hi;
        bit f;
        ref_div(w, a, b, s, lo, hi, f);
        chk("model_lo",   (w == 8) ? 0 : 2, lo, elo);
        chk("model_hi",   (w == 8) ? 0 : 2, hi, ehi);
        chk("model_flag", (w == 8) ? 0 : 2, 32'(f), 32'(ef));
    endtask

    // One operation with literal expectations; operands are scrambled while busy.
    task automatic run_dir(input int i, input logic [31:0] a, input logic [31:0] b, input bit s,
                           input logic [31:0] elo, input logic [31:0] ehi, input bit ef,
                           input int elat);
        int lat;
        lat = -1;
        @(negedge clk);
        start_s[i] = 1'b1; sop_s[i] = s; dvd_s[i] = a; dvs_s[i] = b;
        @(negedge clk);
        start_s[i] = 1'b0;
        sop_s[i]   = ~s;
        dvd_s[i]   = $urandom & mask_of(wid(i));
        dvs_s[i]   = $urandom & mask_of(wid(i));
        chk("busy_after_start", i, 32'(busy_s[i]), 32'd1);
        chk("flag_clear_on_start", i, 32'(flag_s[i]), 32'd0);
        for (int k = 0; k <= 100; k++) begin
            if (done_s[i]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("latency", i, 32'(lat), 32'(elat));
        chk("dir_lo",  i, lo_s[i], elo);
        chk("dir_hi",  i, hi_s[i], ehi);
        chk("dir_flag", i, 32'(flag_s[i]), 32'(ef));
        $display("op w%0d %s 0x%0h / 0x%0h -> lo=0x%0h hi=0x%0h flag=%0d lat=%0d",
                 wid(i), s ? "signed" : "unsigned", a, b, lo_s[i], hi_s[i], flag_s[i], lat);
    endtask

    function automatic logic [31:0] rnd_op(input int w);
        logic [31:0] m;
        m = mask_of(w);
        case ($urandom_range(6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return 32'd1 << (w - 1);
            4:       return 32'($urandom_range(15));
            default: return $urandom & m;
        endcase
    endfunction

    initial begin
        int ndone;
        reset_n = 1'b0;
        start_s = '0;
        sop_s   = '0;
        dvd_s   = '0;
        dvs_s   = '0;
        repeat (3) @(negedge clk);
        chk_zero_all("reset");

        // Pin the reference model with hand-computed results.
        chk_model(32, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        chk_model(32, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        chk_model(32, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        chk_model(8, 32'hC8, 32'h03, 1'b1, 32'hEE, 32'hFE, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;

        // Directed operations.
        run_dir(2, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
        run_dir(2, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        run_dir(2, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, 34);
        run_dir(2, 32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1);
        run_dir(2, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 34);
        run_dir(2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 34);
        run_dir(2, 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
        run_dir(0, 32'hC8, 32'h03, 1'b1, 32'hEE, 32'hFE, 1'b0, 10);
        run_dir(0, 32'h07, 32'hFE, 1'b1, 32'hFD, 32'h01, 1'b0, 10);
        run_dir(1, 32'hFFFF, 32'h0010, 1'b0, 32'h0FFF, 32'h000F, 1'b0, 18);

        // Reset in the middle of an operation abandons it.
        @(negedge clk);
        start_s[2] = 1'b1; sop_s[2] = 1'b0; dvd_s[2] = 32'd5000; dvs_s[2] = 32'd3;
        @(negedge clk);
        start_s[2] = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero_all("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_s[2]) ndone++;
        end
        chk("no_done_after_abort", 2, 32'(ndone), 32'd0);
        run_dir(2, 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 34);

        // Start pulsed while busy is ignored: exactly one done with the first result.
        @(negedge clk);
        start_s[2] = 1'b1; sop_s[2] = 1'b0; dvd_s[2] = 32'd77; dvs_s[2] = 32'd5;
        @(negedge clk);
        start_s[2] = 1'b0;
        repeat (5) @(negedge clk);
        start_s[2] = 1'b1; dvd_s[2] = 32'd1; dvs_s[2] = 32'd0;
        @(negedge clk);
        start_s[2] = 1'b0;
        ndone = 0;
        repeat (45) begin
            if (done_s[2]) begin
                ndone++;
                chk("ignored_start_lo", 2, lo_s[2], 32'd15);
                chk("ignored_start_hi", 2, hi_s[2], 32'd2);
            end
            @(negedge clk);
        end
        chk("ignored_start_dones", 2, 32'(ndone), 32'd1);

        // Randomized traffic; the middle stretch holds start high for back-to-back ops.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start_s[i] = (c >= 1500 && c < 2500) ? 1'b1 : ($urandom_range(3) == 0);
                sop_s[i]   = 1'($urandom_range(1));
                dvd_s[i]   = rnd_op(wid(i));
                dvs_s[i]   = rnd_op(wid(i));
            end
        end
        start_s = '0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
